// File: rtl/rx_sync_pkg.sv
// Shared types and constants for the rx_sync link-synchronization controller.
package rx_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCK   = 2'd2,
        ACTIVE = 2'd3
    } rx_sync_state_t;

    localparam logic [7:0] COMMA_BC = 8'hBC;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_sync_timer.sv
// Clearable, wrapping up-counter with terminal-count flag; shared between the
// HUNT slip timer and the ACTIVE comma watchdog.
module rx_sync_timer
    import rx_sync_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk_4f,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count_r;

    assign tc = (count_r == term);

    // Count register: clear wins, then wrap at the terminal value.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            if (tc) begin
                count_r <= {W{1'b0}};
            end else begin
                count_r <= count_r + W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Byte-alignment controller: hunts for commas, slips the deserializer, locks and
// forwards payload. Define RX_SYNC_STATS_EN to add the loss_cnt statistics port.
module rx_sync_ctrl
    import rx_sync_pkg::*;
#(
    parameter logic [7:0] COMMA     = COMMA_BC,
    parameter int         LOCK_CNT  = 4,
    parameter int         SLIP_WAIT = 8,
    parameter int         WDOG_MAX  = 64
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       slip,
    output logic [2:0] slip_cnt,
    output logic       sync_lost
`ifdef RX_SYNC_STATS_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int LOCK_W = $clog2(LOCK_CNT);
    localparam int TMR_W  = $clog2(max_int(SLIP_WAIT, WDOG_MAX));
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CNT - 1);
    localparam logic [TMR_W-1:0]  SLIP_LAST = TMR_W'(SLIP_WAIT - 1);
    localparam logic [TMR_W-1:0]  WDOG_LAST = TMR_W'(WDOG_MAX - 1);

    rx_sync_state_t    state_r;
    logic [LOCK_W-1:0] lock_cnt_r;
    logic [7:0]        data_out_r;
    logic              valid_r;
    logic              active_r;
    logic              slip_r;
    logic [2:0]        slip_cnt_r;
    logic              sync_lost_r;

    logic              comma_s;
    logic              expire_s;
    logic              tmr_clr_s;
    logic              tmr_inc_s;
    logic [TMR_W-1:0]  tmr_term_s;
    logic              tmr_tc_s;

    assign comma_s  = (data_in == COMMA);
    assign expire_s = enable && (state_r == ACTIVE) && !comma_s && tmr_tc_s;

    // Timer control: counts non-commas in HUNT/ACTIVE, held clear elsewhere.
    always_comb begin
        tmr_clr_s  = 1'b1;
        tmr_inc_s  = 1'b0;
        tmr_term_s = (state_r == ACTIVE) ? WDOG_LAST : SLIP_LAST;
        if (!enable) begin
            tmr_clr_s = 1'b1;
        end else begin
            case (state_r)
                HUNT, ACTIVE: begin
                    tmr_clr_s = comma_s;
                    tmr_inc_s = !comma_s;
                end
                IDLE, LOCK: tmr_clr_s = 1'b1;
                default:    tmr_clr_s = 1'b1;
            endcase
        end
    end

    rx_sync_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_4f (clk_4f),
        .reset  (reset),
        .clr    (tmr_clr_s),
        .inc    (tmr_inc_s),
        .term   (tmr_term_s),
        .tc     (tmr_tc_s)
    );

    // Synchronization FSM with all outputs registered.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            lock_cnt_r  <= {LOCK_W{1'b0}};
            data_out_r  <= 8'h00;
            valid_r     <= 1'b0;
            active_r    <= 1'b0;
            slip_r      <= 1'b0;
            slip_cnt_r  <= 3'd0;
            sync_lost_r <= 1'b0;
        end else if (!enable) begin
            state_r     <= IDLE;
            lock_cnt_r  <= {LOCK_W{1'b0}};
            data_out_r  <= 8'h00;
            valid_r     <= 1'b0;
            active_r    <= 1'b0;
            slip_r      <= 1'b0;
            slip_cnt_r  <= 3'd0;
            sync_lost_r <= 1'b0;
        end else begin
            data_out_r  <= data_in;
            valid_r     <= 1'b0;
            slip_r      <= 1'b0;
            sync_lost_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r    <= HUNT;
                    data_out_r <= 8'h00;
                    slip_cnt_r <= 3'd0;
                    lock_cnt_r <= {LOCK_W{1'b0}};
                    active_r   <= 1'b0;
                end
                HUNT: begin
                    active_r <= 1'b0;
                    if (comma_s) begin
                        state_r    <= LOCK;
                        lock_cnt_r <= LOCK_W'(1);
                    end else if (tmr_tc_s) begin
                        slip_r     <= 1'b1;
                        slip_cnt_r <= slip_cnt_r + 3'd1;
                    end
                end
                LOCK: begin
                    if (!comma_s) begin
                        state_r    <= HUNT;
                        lock_cnt_r <= {LOCK_W{1'b0}};
                    end else if (lock_cnt_r == LOCK_LAST) begin
                        state_r    <= ACTIVE;
                        lock_cnt_r <= {LOCK_W{1'b0}};
                        active_r   <= 1'b1;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
                    end
                end
                ACTIVE: begin
                    if (expire_s) begin
                        state_r     <= HUNT;
                        active_r    <= 1'b0;
                        sync_lost_r <= 1'b1;
                    end else begin
                        valid_r <= !comma_s;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    lock_cnt_r <= {LOCK_W{1'b0}};
                    active_r   <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign active    = active_r;
    assign slip      = slip_r;
    assign slip_cnt  = slip_cnt_r;
    assign sync_lost = sync_lost_r;

`ifdef RX_SYNC_STATS_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of watchdog expiries; survives enable, cleared by reset only.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            loss_cnt_r <= 8'h00;
        end else if (expire_s && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'h01;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_cnt = loss_cnt_r;
`endif

endmodule

// File: doc/rx_sync_ctrl.md
# rx_sync_ctrl

Link-synchronization controller for the PHY receive path: it sits behind the serial-to-parallel receiver, in the clk_4f domain, and sequences byte alignment. It hunts for the 0xBC comma and commands bit-slips to the deserializer until commas appear. It declares the link active after consecutive commas, then forwards non-comma bytes as valid data. A comma watchdog drops the link back to hunting when sync is lost.

## Interface
- COMMA, 8'hBC, idle/alignment character
- LOCK_CNT, 4, consecutive commas required to enter ACTIVE (≥2)
- SLIP_WAIT, 8, cycles without a comma in HUNT before a slip is issued (≥2)
- WDOG_MAX, 64, cycles without a comma in ACTIVE before sync is declared lost

- clk_4f  in  1  byte clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  synchronization enable; low forces IDLE
- data_in  in  8  parallel byte from the deserializer, one per clk_4f
- data_out  out  8  registered copy of data_in
- valid_out  out  1  data_out holds payload
- active  out  1  link synchronized (state == ACTIVE)
- slip  out  1  one-cycle pulse: deserializer shifts its alignment by one bit
- slip_cnt  out  3  number of slips since last HUNT entry from IDLE, wraps mod 8
- sync_lost  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, HUNT, LOCK, ACTIVE.
- Reset value: state=IDLE, data_out=0, valid_out=0, active=0, slip=0, slip_cnt=0, sync_lost=0, all counters 0.
- IDLE: go to HUNT when enable=1. slip_cnt is cleared on this transition.
- HUNT: comma sampled -> LOCK with comma count=1, hunt timer cleared. Otherwise the hunt timer increments. When it reaches SLIP_WAIT-1 it wraps to 0, and on that edge slip=1 and slip_cnt increments.
- LOCK: comma -> count increments; reaching LOCK_CNT -> ACTIVE. Non-comma -> HUNT with count=0, hunt timer=0, and no immediate slip.
- ACTIVE: a comma clears the watchdog; a non-comma increments it. Reaching WDOG_MAX-1 on a non-comma -> HUNT, with sync_lost=1 for one cycle and the hunt timer cleared.
- data_out <= data_in on every edge in every state except IDLE (in IDLE it is held at 0).
- valid_out <= 1 only when the state before the edge is ACTIVE, the ACTIVE->HUNT transition is not taken, and data_in != COMMA. Otherwise 0.
- active is the registered state decode; it is never combinational from data_in.
- Counters have minimal width ($clog2 of their parameter) and never overflow: each is cleared or wrapped at its terminal value.

## Timing
- Data latency: 1 clk_4f, from data_in to data_out/valid_out.
- With commas starting at cycle n (sampled at edge n), active rises at edge n+LOCK_CNT-1. The first valid_out is the first non-comma sampled at or after edge n+LOCK_CNT.
- slip is asserted on the edge after SLIP_WAIT consecutive non-comma samples in HUNT. Slips repeat every SLIP_WAIT cycles. slip is never asserted outside HUNT.
- Simultaneous events:
  - enable=0 beats everything: next state IDLE, outputs cleared, no slip or sync_lost pulse.
  - A comma on the watchdog-expiry cycle prevents expiry.
- reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). Operation resumes in IDLE on the first edge after deassertion.

## Configuration
- RX_SYNC_STATS_EN defined: adds output loss_cnt [7:0], which counts sync_lost pulses. It saturates at 255, is cleared only by reset, and is not cleared by enable.
- RX_SYNC_STATS_EN undefined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Shared package rx_sync_pkg:
  - state enum rx_sync_state_t (IDLE, HUNT, LOCK, ACTIVE)
  - constant COMMA_BC = 8'hBC, which the instance uses as the COMMA default
- Sub-module rx_sync_timer: a clearable, wrapping up-counter with a terminal-count flag. One instance serves as the hunt timer (HUNT) and as the watchdog (ACTIVE), since only one runs per state.
- The FSM, the output registers and the LOCK comma counter stay in rx_sync_ctrl.

## Test plan
- Reset then enable=1, data_in=0xBC constantly -> active=1 at the 4th sampled comma. valid_out stays 0. No slip.
- Bytes 0xBC ×4 then 0x12, 0x34 -> data_out 0x12 and 0x34 each with valid_out=1, one cycle after input.
- data_in=0x5E constantly -> slip pulses at cycles 8, 16, 24…; slip_cnt counts 1,2,3…; it wraps 7->0 after 8 slips.
- BC, BC, 0x00, BC… in LOCK -> returns to HUNT on 0x00 with no slip. Lock requires 4 fresh consecutive commas.
- In ACTIVE, 64 non-comma bytes -> sync_lost pulse, active=0, valid_out=0 on the expiry edge. With a comma at byte 63 instead: no loss. With RX_SYNC_STATS_EN, loss_cnt=1.
- Drop enable in ACTIVE, and separately assert reset mid-LOCK -> all outputs at reset values. Relock succeeds afterwards.
